// File: rtl/combo_entry.sv
// Combination-entry front end: synchronizes and debounces two push buttons and
// the combination switches, emits single-cycle press pulses and holds the stored code.

module combo_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          stable_r;
  logic          stable_prev_r;
  logic          rise_r;
  logic [CW-1:0] cnt_r;

  // Two-flop synchronizer for the raw asynchronous button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: accept a change only after it has persisted DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_r <= 1'b0;
      cnt_r    <= '0;
    end else if (sync2_r == stable_r) begin
      stable_r <= stable_r;
      cnt_r    <= '0;
    end else if (cnt_r == LAST_CNT) begin
      stable_r <= sync2_r;
      cnt_r    <= '0;
    end else begin
      stable_r <= stable_r;
      cnt_r    <= cnt_r + CW'(1);
    end
  end

  // Registered rising-edge detect on the debounced level; releases are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_prev_r <= 1'b0;
      rise_r        <= 1'b0;
    end else begin
      stable_prev_r <= stable_r;
      rise_r        <= stable_r & ~stable_prev_r;
    end
  end

  assign rise = rise_r;

endmodule

module combo_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic [3:0]  RESET_COMBO     = 4'b0110
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       enter_btn,
  input  logic       change_btn,
  input  logic [3:0] sw,
  input  logic       set,
  output logic       enter,
  output logic       change,
  output logic       isCombo,
  output logic [3:0] combo
);

  logic       enter_rise_s;
  logic       change_rise_s;
  logic [3:0] sw_sync1_r;
  logic [3:0] sw_sync2_r;
  logic [3:0] combo_r;
  logic       enter_r;
  logic       change_r;

  combo_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
    .clk  (Clock),
    .rst  (Reset),
    .btn  (enter_btn),
    .rise (enter_rise_s)
  );

  combo_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_change_db (
    .clk  (Clock),
    .rst  (Reset),
    .btn  (change_btn),
    .rise (change_rise_s)
  );

  // Per-bit two-flop synchronizer for the combination switches.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sw_sync1_r <= 4'b0000;
      sw_sync2_r <= 4'b0000;
    end else begin
      sw_sync1_r <= sw;
      sw_sync2_r <= sw_sync1_r;
    end
  end

  // Pulse outputs; enter wins when both buttons are accepted on the same edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      enter_r  <= 1'b0;
      change_r <= 1'b0;
    end else begin
      enter_r  <= enter_rise_s;
      change_r <= change_rise_s & ~enter_rise_s;
    end
  end

  // Stored combination, reloaded on every cycle set is held.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      combo_r <= RESET_COMBO;
    end else if (set) begin
      combo_r <= sw_sync2_r;
    end else begin
      combo_r <= combo_r;
    end
  end

  assign enter   = enter_r;
  assign change  = change_r;
  assign combo   = combo_r;
  assign isCombo = (sw_sync2_r == combo_r);

endmodule
